// File: rtl/mem_cache.sv
// mem_cache: direct-mapped write-through no-write-allocate one-word-line cache.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count read statistics.
module mem_cache #(
    parameter int NUM_LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

    state_t               state_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES];
    logic [31:0]          rdata_q, addr_q, wdata_q;
    logic                 ready_q, mrd_q, mwr_q;
    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic                 hit;

    assign idx = cpu_addr[IDX_W-1:0];
    assign tag = cpu_addr[31:IDX_W];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    assign cpu_rdata = rdata_q;
    assign cpu_ready = ready_q;
    assign mem_read  = mrd_q;
    assign mem_write = mwr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_write) begin
                        state_q <= WRITE;
                        mwr_q   <= 1'b1;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                    end else if (cpu_read && hit) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        rdata_q <= data_q[idx];
                    end else if (cpu_read) begin
                        state_q <= FILL;
                        mrd_q   <= 1'b1;
                        addr_q  <= cpu_addr;
                    end
                end
                FILL: begin
                    state_q      <= RESP;
                    mrd_q        <= 1'b0;
                    ready_q      <= 1'b1;
                    rdata_q      <= mem_rdata;
                    valid_q[idx] <= 1'b1;
                end
                WRITE: begin
                    state_q <= RESP;
                    mwr_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Tag/data arrays carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (state_q == FILL) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= mem_rdata;
        end else if (state_q == WRITE && hit) begin
            data_q[idx] <= cpu_wdata;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hits_q, misses_q;
    logic        take_rd;

    assign take_rd    = (state_q == IDLE) && cpu_read && !cpu_write;
    assign hit_count  = hits_q;
    assign miss_count = misses_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (take_rd) begin
            hits_q   <= (hit && hits_q != '1) ? hits_q + 32'd1 : hits_q;
            misses_q <= (!hit && misses_q != '1) ? misses_q + 32'd1 : misses_q;
        end
    end
`endif
endmodule

// File: tb/tb_mem_cache.sv
// tb_mem_cache: table-driven directed checks of mem_cache against a word memory model.
module tb_mem_cache;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_read = 1'b0, cpu_write = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ready, mem_read, mem_write;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_cache #(.NUM_LINES(64)) dut (
        .clk(clk), .rst(rst),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    logic [31:0] mem [256];
    bit          written [256];

    function automatic logic [31:0] init_word(input logic [7:0] a);
        return (a == 8'd5) ? 32'hA5A5_A5A5 : (32'hC0DE_0000 | {24'd0, a});
    endfunction

    assign mem_rdata = written[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_word(mem_addr[7:0]);

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[7:0]]     <= mem_wdata;
            written[mem_addr[7:0]] <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output int nmr, output int nmw, output int aerr,
                       output logic [31:0] rdat);
        lat = 0; nmr = 0; nmw = 0; aerr = 0;
        @(negedge clk);
        cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
        rdat = cpu_rdata;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            lat++;
            if (mem_read) begin
                nmr++;
                if (mem_addr !== a) aerr++;
            end
            if (mem_write) begin
                nmw++;
                if (mem_addr !== a || mem_wdata !== d) aerr++;
            end
            if (cpu_ready) begin
                rdat = cpu_rdata;
                break;
            end
        end
        cpu_read = 1'b0; cpu_write = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wdata;
        int          lat, nmr, nmw;
        logic [31:0] rdata;
    } vec_t;

    vec_t v [10];
    int lat, nmr, nmw, aerr;
    logic [31:0] rdat;

    initial begin
        v[0] = '{1'b1, 1'b0, 32'd5,   32'd0,          2, 1, 0, 32'hA5A5_A5A5};
        v[1] = '{1'b1, 1'b0, 32'd5,   32'd0,          1, 0, 0, 32'hA5A5_A5A5};
        v[2] = '{1'b1, 1'b0, 32'd69,  32'd0,          2, 1, 0, 32'hC0DE_0045};
        v[3] = '{1'b1, 1'b0, 32'd5,   32'd0,          2, 1, 0, 32'hA5A5_A5A5};
        v[4] = '{1'b0, 1'b1, 32'd5,   32'h1234_5678,  2, 0, 1, 32'hA5A5_A5A5};
        v[5] = '{1'b1, 1'b0, 32'd5,   32'd0,          1, 0, 0, 32'h1234_5678};
        v[6] = '{1'b0, 1'b1, 32'd100, 32'hDEAD_BEEF,  2, 0, 1, 32'h1234_5678};
        v[7] = '{1'b1, 1'b0, 32'd100, 32'd0,          2, 1, 0, 32'hDEAD_BEEF};
        v[8] = '{1'b1, 1'b1, 32'd7,   32'h0000_0077,  2, 0, 1, 32'hDEAD_BEEF};
        v[9] = '{1'b1, 1'b0, 32'd7,   32'd0,          2, 1, 0, 32'h0000_0077};

        #23;
        check("reset_outputs", {cpu_rdata, mem_addr, mem_wdata, 29'd0, cpu_ready, mem_read, mem_write}, '0);
        @(negedge clk); rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            req(v[i].rd, v[i].wr, v[i].addr, v[i].wdata, lat, nmr, nmw, aerr, rdat);
            check($sformatf("v%0d_latency", i), lat, v[i].lat);
            check($sformatf("v%0d_mem_read_cycles", i), nmr, v[i].nmr);
            check($sformatf("v%0d_mem_write_cycles", i), nmw, v[i].nmw);
            check($sformatf("v%0d_mem_addr_wdata", i), aerr, 0);
            check($sformatf("v%0d_rdata", i), rdat, v[i].rdata);
        end

        @(negedge clk);
        cpu_read = 1'b1; cpu_addr = 32'd9;
        @(posedge clk); #1;
        check("fill_mem_read", mem_read, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("async_drop_mem_read", mem_read, 1'b0);
        check("async_drop_mem_addr", mem_addr, 32'd0);
        cpu_read = 1'b0;
        @(negedge clk); @(negedge clk); rst = 1'b1;
        req(1'b1, 1'b0, 32'd9, 32'd0, lat, nmr, nmw, aerr, rdat);
        check("post_reset_9_latency", lat, 2);
        check("post_reset_9_mem_read", nmr, 1);
        check("post_reset_9_rdata", rdat, 32'hC0DE_0009);
        req(1'b1, 1'b0, 32'd5, 32'd0, lat, nmr, nmw, aerr, rdat);
        check("post_reset_5_miss", nmr, 1);
        check("post_reset_5_rdata", rdat, 32'h1234_5678);

`ifdef CACHE_STATS_EN
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("stats_reset", {hit_count, miss_count}, 64'd0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) req(1'b1, 1'b0, 32'd11, 32'd0, lat, nmr, nmw, aerr, rdat);
        check("stats_miss", miss_count, 32'd1);
        check("stats_hit", hit_count, 32'd2);
        req(1'b0, 1'b1, 32'd11, 32'h5555_AAAA, lat, nmr, nmw, aerr, rdat);
        req(1'b0, 1'b1, 32'd12, 32'h5555_AAAA, lat, nmr, nmw, aerr, rdat);
        check("stats_write_miss", miss_count, 32'd1);
        check("stats_write_hit", hit_count, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_cache.md
Name: mem_cache

Overview:
- Direct-mapped, write-through, no-write-allocate cache between the multi-cycle datapath's memory request and the word-addressed main memory.
- Serves read hits without a main-memory access.
- Main memory has a combinational read (data valid in the same cycle as address and read-enable) and a write clocked on posedge.
- One line holds one 32-bit word; addresses are word indices.

Parameters:
- NUM_LINES, 64, number of cache lines; must be a power of 2, minimum 2.
- IDX_W, $clog2(NUM_LINES), index width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous reset, active-low.
- cpu_read  input  1  read request; held stable until cpu_ready.
- cpu_write  input  1  write request; held stable until cpu_ready.
- cpu_addr  input  32  word address.
- cpu_wdata  input  32  write data.
- cpu_rdata  output  32  read data; valid while cpu_ready=1 on a read.
- cpu_ready  output  1  one-cycle completion pulse.
- mem_read  output  1  main-memory read enable.
- mem_write  output  1  main-memory write enable.
- mem_addr  output  32  main-memory address.
- mem_wdata  output  32  main-memory write data.
- mem_rdata  input  32  main-memory read data (combinational).

Behaviour:
- Address split: index = cpu_addr[IDX_W-1:0], tag = cpu_addr[31:IDX_W]. Per line: valid bit, tag, 32-bit data.
- Reset (rst=0, asynchronous): all valid bits 0, state IDLE, cpu_ready=0, cpu_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. Tag and data arrays are not cleared.
- FSM states:
  - IDLE: accepts requests only here.
    - cpu_write=1 -> WRITE. Write wins if cpu_read is also 1.
    - Else cpu_read=1 and hit (valid && tag match) -> RESP. cpu_rdata is loaded with the line data at that edge.
    - Else cpu_read=1 and miss -> FILL.
    - No request -> stay in IDLE.
  - FILL: exactly one cycle. Drives mem_read=1 and mem_addr=cpu_addr. At the closing edge: line data=mem_rdata, tag written, valid=1, cpu_rdata=mem_rdata. Next state RESP.
  - WRITE: exactly one cycle. Drives mem_write=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
    - On a hit, line data is updated with cpu_wdata at the closing edge.
    - On a miss, the line is left untouched (no allocate).
    - Next state RESP.
  - RESP: cpu_ready=1 for exactly this cycle. Requests are ignored. Next state IDLE. The requester must drop its request by the cycle after cpu_ready.
- mem_read and mem_write are 0 in every state other than FILL and WRITE respectively. mem_addr and mem_wdata are registered, or decoded from state, glitch-free relative to the enables.
- Latency from the edge that samples the request to the cpu_ready cycle:
  - read hit: 1 cycle.
  - read miss: 2 cycles.
  - write (hit or miss): 2 cycles.
- cpu_rdata holds its last value outside RESP. On writes it is unchanged.
- Reset mid-FILL or mid-WRITE: the state is abandoned immediately and enables drop asynchronously. No line is updated. A memory write in flight is not guaranteed.
- Conflicting addresses sharing an index evict each other. There is no dirty state; eviction is silent.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: adds output ports hit_count[31:0] and miss_count[31:0].
  - hit_count increments on each read accepted in IDLE that hits.
  - miss_count increments on each read accepted in IDLE that misses.
  - Writes are not counted.
  - Both saturate at 32'hFFFF_FFFF.
  - Both reset to 0 on rst=0.
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Read miss:
  - Setup: reset, memory word 5 = 32'hA5A5_A5A5.
  - Stimulus: read addr 5.
  - Required: one cycle of mem_read=1 with mem_addr=5; cpu_ready 2 cycles after sampling; cpu_rdata=32'hA5A5_A5A5.
- Read hit:
  - Stimulus: read addr 5 again.
  - Required: no mem_read; cpu_ready after 1 cycle; cpu_rdata=32'hA5A5_A5A5.
- Conflict eviction:
  - Setup: NUM_LINES=64.
  - Stimulus: read addr 69 (same index as 5), then read addr 5.
  - Required: both reads miss with a FILL each; data returned is memory words 69 and 5.
- Write hit and write miss:
  - Stimulus: write addr 5 = 32'h1234_5678.
  - Required: one cycle of mem_write with mem_addr=5 and mem_wdata=32'h1234_5678; a following read of addr 5 hits and returns 32'h1234_5678.
  - Stimulus: write addr 100, then read addr 100.
  - Required: the write asserts mem_write; the read misses (no allocate).
- Simultaneous request and reset mid-operation:
  - Stimulus: cpu_read=cpu_write=1 on addr 7.
  - Required: the WRITE path is taken; no FILL.
  - Stimulus: assert rst=0 during the FILL for addr 9.
  - Required: mem_read drops without waiting for an edge; after release, a read of addr 9 misses.
- Stats (CACHE_STATS_EN defined):
  - Stimulus: after reset, run 3 reads of the same address.
  - Required: miss_count=1, hit_count=2; writes leave both unchanged.
